// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-write-port / single-read-port RAM with a
// one-cycle registered read among NUM_PORTS requesters. Writes and reads are
// arbitrated by two independent round-robin arbiters, so one write and one
// read may be granted in the same cycle.
module ram_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            wr_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_PORTS-1:0]            wr_gnt,
    input  logic [NUM_PORTS-1:0]            rd_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_PORTS-1:0]            rd_gnt,
    output logic [NUM_PORTS-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            ram_wen,
    output logic [ADDR_WIDTH-1:0]           ram_w_addr,
    output logic [ADDR_WIDTH-1:0]           ram_r_addr,
    output logic [DATA_WIDTH-1:0]           ram_data_in,
    input  logic [DATA_WIDTH-1:0]           ram_data_out
);

    localparam int LW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [LW-1:0] LAST_RST = LW'(NUM_PORTS - 1);

    logic [LW-1:0]        wr_last_q, wr_last_d;
    logic [LW-1:0]        rd_last_q, rd_last_d;
    logic [NUM_PORTS-1:0] rd_valid_q, rd_valid_d;

    logic                 wr_hit, rd_hit;
    logic [LW-1:0]        wr_idx, rd_idx;
    logic [LW-1:0]        wr_sel, rd_sel;

    // Write arbiter: first requester in order last+1 .. last wins; forced idle in reset
    always_comb begin
        logic [LW-1:0] cand;
        wr_hit = 1'b0;
        wr_idx = '0;
        wr_gnt = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = LW'((int'(wr_last_q) + int'(k)) % NUM_PORTS);
            if (!wr_hit && reset_n && wr_req[cand]) begin
                wr_hit = 1'b1;
                wr_idx = cand;
            end
        end
        if (wr_hit) begin
            wr_gnt[wr_idx] = 1'b1;
        end
        wr_last_d = wr_hit ? wr_idx : wr_last_q;
    end

    // Read arbiter: identical rotation, independent pointer
    always_comb begin
        logic [LW-1:0] cand;
        rd_hit = 1'b0;
        rd_idx = '0;
        rd_gnt = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = LW'((int'(rd_last_q) + int'(k)) % NUM_PORTS);
            if (!rd_hit && reset_n && rd_req[cand]) begin
                rd_hit = 1'b1;
                rd_idx = cand;
            end
        end
        if (rd_hit) begin
            rd_gnt[rd_idx] = 1'b1;
        end
        rd_last_d  = rd_hit ? rd_idx : rd_last_q;
        rd_valid_d = rd_gnt;
    end

    // RAM-side muxing: granted port's fields, port 0 when idle
    always_comb begin
        wr_sel      = wr_hit ? wr_idx : '0;
        rd_sel      = rd_hit ? rd_idx : '0;
        ram_wen     = |wr_gnt;
        ram_w_addr  = wr_addr[int'(wr_sel)*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data_in = wr_data[int'(wr_sel)*DATA_WIDTH +: DATA_WIDTH];
        ram_r_addr  = rd_addr[int'(rd_sel)*ADDR_WIDTH +: ADDR_WIDTH];
        rd_data     = ram_data_out;
        rd_valid    = rd_valid_q;
    end

    // Arbiter pointers and read-valid pipeline stage aligned to the RAM output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_last_q  <= LAST_RST;
            rd_last_q  <= LAST_RST;
            rd_valid_q <= '0;
        end else begin
            wr_last_q  <= wr_last_d;
            rd_last_q  <= rd_last_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin access controller that shares one `ram` instance (one write port, one read port, one-cycle registered read) among `NUM_PORTS` requesters, such as labelling, flood-fill and statistics engines. Writes and reads are arbitrated independently, so one write and one read can be granted in the same cycle. The block drives the RAM-side address, data and enable lines and returns read data with a per-port valid strobe aligned to the RAM's output register.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters; ≥ 2.
- `ADDR_WIDTH`, 8: RAM address width.
- `DATA_WIDTH`, 32: RAM data width.

Ports (`N` = `NUM_PORTS`; port *i* occupies slice `[i*W +: W]` of flattened buses):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_req`  in  N  per-port write request.
- `wr_addr`  in  N*ADDR_WIDTH  per-port write address.
- `wr_data`  in  N*DATA_WIDTH  per-port write data.
- `wr_gnt`  out  N  one-hot (or zero) write grant, same cycle as request.
- `rd_req`  in  N  per-port read request.
- `rd_addr`  in  N*ADDR_WIDTH  per-port read address.
- `rd_gnt`  out  N  one-hot (or zero) read grant, same cycle as request.
- `rd_valid`  out  N  one-hot (or zero); `rd_data` is valid for the flagged port.
- `rd_data`  out  DATA_WIDTH  read data, shared by all ports.
- `ram_wen`  out  1  to RAM `wen`.
- `ram_w_addr`  out  ADDR_WIDTH  to RAM `w_addr`.
- `ram_r_addr`  out  ADDR_WIDTH  to RAM `r_addr`.
- `ram_data_in`  out  DATA_WIDTH  to RAM `data_in`.
- `ram_data_out`  in  DATA_WIDTH  from RAM `data_out`.

## Operation
- Two independent arbiters, write and read. Each holds a registered `last` index of width clog2(N).
- Priority order for a cycle: `last+1, last+2, …, last` (mod N). The first requesting port in this order is granted.
- `last` updates to the granted index only in cycles with a grant. With no requests, `last` holds.
- Grants are combinational from `*_req` and `last`. At most one bit of each grant vector is set. Grant is zero iff the request vector is zero.
- Handshake: a transfer occurs in the cycle where `*_req[i] & *_gnt[i]`. A requester holds `req`, `addr` and `data` stable until granted. The arbiter requires no acknowledge beyond the grant.
- Write path:
  - `ram_wen` = OR of `wr_gnt`.
  - `ram_w_addr` and `ram_data_in` = granted port's fields.
  - With no grant, these fields are driven from port 0 and `ram_wen`=0.
- Read path:
  - `ram_r_addr` = granted port's address, or port 0's address when idle.
  - Registered `rd_valid` <= `rd_gnt` each cycle.
  - `rd_data` = `ram_data_out`, passed through combinationally.
- Same-cycle write and read to the same address: no forwarding. The read returns the pre-write contents (RAM read-before-write behaviour).
- A port may have `wr_req` and `rd_req` high simultaneously. The two arbiters handle them independently.

## Timing
- Reset (async assert, any time):
  - `rd_valid`=0; both `last`=N-1, so port 0 has highest priority first.
  - Combinational outputs follow the inputs with the reset state. During reset, grants are forced to 0 and `ram_wen`=0.
  - A read granted in the cycle reset asserts never produces `rd_valid`.
- Reset deassertion: arbitration begins on the first rising edge with `reset_n`=1.
- Write latency: the RAM is updated at the edge ending the grant cycle.
- Read latency: 1 cycle. A grant in cycle T gives `rd_valid` and `rd_data` in cycle T+1.
- Throughput: 1 write + 1 read per cycle sustained. Back-to-back reads to different ports give consecutive `rd_valid` bits.
- Fairness bound: a continuously requesting port is granted within N cycles.
- Wrap-around: `last`=N-1 wraps to search order starting at port 0.

## Test plan
- Reset then single request: `reset_n` 0→1; `wr_req`=4'b0100, addr 8'h10, data 32'hDEAD_BEEF. Required: `wr_gnt`=4'b0100 same cycle; `ram_wen`=1; `ram_w_addr`=8'h10. Next cycle, port 1 reads 8'h10: `rd_gnt`=4'b0010, then `rd_valid`=4'b0010 with `rd_data`=32'hDEAD_BEEF.
- Round-robin rotation: all four ports hold `rd_req` for 8 cycles after reset. Required: grants 0,1,2,3,0,1,2,3. Each `rd_valid` lags its grant by one cycle with the matching data.
- Sparse fairness: ports 1 and 3 hold `wr_req`, last granted = 1. Required: next grant is 3, then 1, alternating. Ports 0 and 2 are never granted; `last` is unchanged in idle cycles.
- Concurrent read/write with collision: port 0 writes 32'h1 to 8'h20 while port 2 reads 8'h20 (old value 32'h0) in the same cycle. Required: both granted; `rd_data`=32'h0 next cycle. A reread one cycle later returns 32'h1.
- Reset mid-operation: assert `reset_n`=0 asynchronously in the cycle a read is granted. Required: `rd_valid` drops to 0 immediately and stays 0 the following cycle. After release, port 0 wins a 4'b1111 request.
- Stability: hold `wr_req`=4'b1000 with no grant blocking for 3 cycles. Required: `wr_gnt`=4'b1000 every cycle; three RAM writes occur; `last`=3.
